sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO that succeeds the fixed 8-bit/1024-entry data buffer. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. It also adds a synchronous flush and a selectable read mode: registered read or first-word-fall-through (FWFT). It sits between byte/word producers and consumers in the datapath.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 10, log2 of depth; DEPTH = 2**ADDR_W entries (>=2)
AF_THRESH, 2**ADDR_W-4, almost_full asserts when level >= AF_THRESH (1..DEPTH)
AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush; empties FIFO and clears error flags
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read/pop request
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data is valid this cycle
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values: level=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, rd_data=0 (FWFT=0), overflow=0, underflow=0. Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits wide. Memory is indexed by the low ADDR_W bits; wrap is natural modulo 2**(ADDR_W+1).
- level = wr_ptr - rd_ptr, truncated to ADDR_W+1 bits.
- All flags decode combinationally from the registered pointers; no status output glitches on inputs.
- Write acceptance: wr_acc = wr_en & !full & !clr. On acceptance, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read acceptance: rd_acc = rd_en & !empty & !clr. On acceptance, rd_ptr increments.
- Acceptance uses flags from the start of the cycle:
  - write while full with a simultaneous read: read accepted, write rejected, overflow set.
  - read while empty with a simultaneous write: write accepted, read rejected, underflow set.
- Simultaneous accepted read and write: level is unchanged; both pointers advance.
- FWFT=0 read timing:
  - rd_acc in cycle N registers mem[rd_ptr] into rd_data and sets rd_valid=1 in cycle N+1.
  - rd_valid is 0 after any cycle without rd_acc; rd_data holds its last value.
- FWFT=1 read timing:
  - rd_data = mem[rd_ptr[ADDR_W-1:0]] combinationally; rd_valid = !empty.
  - rd_en acts as a pop acknowledge.
  - A word written to an empty FIFO is visible the cycle after the write.
- Error flags: overflow sets on wr_en & full; underflow sets on rd_en & empty. Both hold until clr or reset. Setting does not alter pointers.
- clr (priority over wr_en/rd_en): next cycle both pointers are 0, level=0, overflow=0, underflow=0, rd_valid=0. In FWFT=0, rd_data holds its value.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight reads are discarded.
- Boundaries:
  - level reaches DEPTH exactly; full and empty are never both 1.
  - The almost flags follow level with no hysteresis.

Test Plan:
- Reset, then write 0x01..0x05 with no reads -> level=5, empty=0, almost_empty=0 (AE_THRESH=4); read 5 times in FWFT=0 -> rd_data 0x01..0x05, each 1 cycle after its rd_en; level=0, empty=1.
- Fill 1024 words (defaults) -> full=1 and almost_full=1 at level 1020; 1025th write -> rejected, overflow=1, level=1024; drain all 1024 -> data in order, empty=1, overflow still 1.
- Read on empty -> underflow=1, rd_valid=0, pointers unchanged; assert clr -> overflow=0, underflow=0, level=0.
- At level=1024, assert wr_en and rd_en together -> read accepted, write rejected, level=1023; at level=0, both together -> write accepted, level=1.
- Stream 3000 words with random wr_en/rd_en (pointer wrap) -> scoreboard matches all data; level never exceeds 1024.
- FWFT=1, DATA_W=16, ADDR_W=3: write 0xBEEF to empty -> next cycle rd_valid=1, rd_data=0xBEEF before any rd_en; pulse rd_en -> rd_valid=0. Assert rst_n low mid-stream -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// error flags, synchronous flush and a selectable read mode
// (registered read or first-word-fall-through).
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int AF_THRESH = 2**ADDR_W - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2**ADDR_W;

    // Constants sized to the pointer width so every compare is width-matched.
    localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_L     = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_L     = (ADDR_W+1)'(AE_THRESH);

    // Storage is deliberately not reset; pointers alone define validity.
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0] wr_ptr_r;
    logic [ADDR_W:0] rd_ptr_r;
    logic            overflow_r;
    logic            underflow_r;

    logic [ADDR_W:0] level_s;
    logic            full_s;
    logic            empty_s;
    logic            wr_acc_s;
    logic            rd_acc_s;

    // Status decode from registered pointers only, so inputs never glitch flags.
    always_comb begin
        level_s  = wr_ptr_r - rd_ptr_r;
        full_s   = (level_s == DEPTH_L);
        empty_s  = (level_s == PTR_ZERO);
        // Acceptance uses start-of-cycle flags; flush overrides both requests.
        wr_acc_s = wr_en & ~full_s  & ~clr;
        rd_acc_s = rd_en & ~empty_s & ~clr;
    end

    assign level        = level_s;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (level_s >= AF_L);
    assign almost_empty = (level_s <= AE_L);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    // Pointer update: flush zeroes both, otherwise advance on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else if (clr) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Sticky error flags: set on a rejected request, cleared only by flush or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clr) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  | (wr_en & full_s);
            underflow_r <= underflow_r | (rd_en & empty_s);
        end
    end

    // Storage write on accepted requests.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; rd_en only acknowledges the pop.
            assign rd_data  = mem_r[rd_ptr_r[ADDR_W-1:0]];
            assign rd_valid = ~empty_s;
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_r;
            logic              rd_valid_r;

            // Registered read: data lands one cycle after the accepted pop.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_r  <= {DATA_W{1'b0}};
                    rd_valid_r <= 1'b0;
                end else if (clr) begin
                    rd_valid_r <= 1'b0;
                end else begin
                    rd_valid_r <= rd_acc_s;
                    if (rd_acc_s) begin
                        rd_data_r <= mem_r[rd_ptr_r[ADDR_W-1:0]];
                    end
                end
            end

            assign rd_data  = rd_data_r;
            assign rd_valid = rd_valid_r;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a default instance (registered read,
// 8x1024) and a small FWFT instance (16x8).
module tb_sync_fifo_param;

    logic clk;
    logic rst_n;

    logic        a_clr, a_wr_en, a_rd_en;
    logic [7:0]  a_wr_data, a_rd_data;
    logic        a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [10:0] a_level;

    logic        b_clr, b_wr_en, b_rd_en;
    logic [15:0] b_wr_data, b_rd_data;
    logic        b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [3:0]  b_level;

    int compared = 0;
    int mismatched = 0;

    sync_fifo_param dut_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr),
        .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .level(a_level),
        .overflow(a_ovf), .underflow(a_udf)
    );

    sync_fifo_param #(.DATA_W(16), .ADDR_W(3), .FWFT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr),
        .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .level(b_level),
        .overflow(b_ovf), .underflow(b_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_d;
        bit w, r, wacc, racc;
        int wcnt, cyc;

        rst_n = 1'b0;
        a_clr = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = 8'h00;
        b_clr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = 16'h0000;
        tick(); tick();

        // Reset state
        chk("rst_level",  32'(a_level), 32'd0);
        chk("rst_empty",  32'(a_empty), 32'd1);
        chk("rst_full",   32'(a_full), 32'd0);
        chk("rst_ae",     32'(a_ae), 32'd1);
        chk("rst_af",     32'(a_af), 32'd0);
        chk("rst_rvalid", 32'(a_rd_valid), 32'd0);
        chk("rst_rdata",  32'(a_rd_data), 32'd0);
        chk("rst_ovf",    32'(a_ovf), 32'd0);
        chk("rst_udf",    32'(a_udf), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write 1..5, watch almost_empty cross the threshold of 4
        for (int i = 1; i <= 5; i++) begin
            a_wr_en = 1'b1; a_wr_data = 8'(i);
            tick();
            chk("w5_level", 32'(a_level), 32'(i));
            chk("w5_ae", 32'(a_ae), (i <= 4) ? 32'd1 : 32'd0);
        end
        a_wr_en = 1'b0;
        chk("w5_empty", 32'(a_empty), 32'd0);

        // Registered reads: data one cycle after rd_en
        for (int i = 1; i <= 5; i++) begin
            a_rd_en = 1'b1;
            tick();
            chk("r5_valid", 32'(a_rd_valid), 32'd1);
            chk("r5_data", 32'(a_rd_data), 32'(i));
        end
        a_rd_en = 1'b0;
        tick();
        chk("r5_valid_low", 32'(a_rd_valid), 32'd0);
        chk("r5_data_hold", 32'(a_rd_data), 32'h05);
        chk("r5_level", 32'(a_level), 32'd0);
        chk("r5_empty", 32'(a_empty), 32'd1);

        // Fill all 1024 entries
        for (int i = 0; i < 1024; i++) begin
            a_wr_en = 1'b1; a_wr_data = 8'(i) ^ 8'h5A;
            tick();
            chk("fill_level", 32'(a_level), 32'(i + 1));
            if (i == 1018) chk("fill_af_1019", 32'(a_af), 32'd0);
            if (i == 1019) chk("fill_af_1020", 32'(a_af), 32'd1);
            if (i == 1022) chk("fill_full_1023", 32'(a_full), 32'd0);
        end
        chk("fill_full", 32'(a_full), 32'd1);
        chk("fill_empty", 32'(a_empty), 32'd0);
        chk("fill_ovf_pre", 32'(a_ovf), 32'd0);
        a_wr_data = 8'hEE;
        tick();
        chk("ovf_set", 32'(a_ovf), 32'd1);
        chk("ovf_level", 32'(a_level), 32'd1024);

        // Write+read at full: read accepted, write rejected
        a_rd_en = 1'b1;
        tick();
        a_wr_en = 1'b0;
        chk("fullboth_level", 32'(a_level), 32'd1023);
        chk("fullboth_data", 32'(a_rd_data), 32'h5A);
        chk("fullboth_valid", 32'(a_rd_valid), 32'd1);

        // Drain the rest in order
        for (int i = 1; i < 1024; i++) begin
            tick();
            chk("drain_data", 32'(a_rd_data), 32'(8'(i) ^ 8'h5A));
        end
        a_rd_en = 1'b0;
        tick();
        chk("drain_empty", 32'(a_empty), 32'd1);
        chk("drain_ovf", 32'(a_ovf), 32'd1);
        chk("drain_level", 32'(a_level), 32'd0);

        // Read while empty
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        chk("udf_set", 32'(a_udf), 32'd1);
        chk("udf_valid", 32'(a_rd_valid), 32'd0);
        chk("udf_level", 32'(a_level), 32'd0);
        chk("udf_hold", 32'(a_rd_data), 32'hA5);

        // Read pointer must not have moved: next write is read back first
        a_wr_en = 1'b1;
        a_wr_data = 8'h11; tick();
        a_wr_data = 8'h22; tick();
        a_wr_data = 8'h33; tick();
        a_wr_en = 1'b0;
        a_rd_en = 1'b1; tick(); a_rd_en = 1'b0;
        chk("udf_ptr_data", 32'(a_rd_data), 32'h11);
        chk("udf_ptr_level", 32'(a_level), 32'd2);

        // Flush with data present
        a_clr = 1'b1; a_wr_en = 1'b1; a_rd_en = 1'b1;
        tick();
        a_clr = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
        chk("clr_level", 32'(a_level), 32'd0);
        chk("clr_empty", 32'(a_empty), 32'd1);
        chk("clr_ovf", 32'(a_ovf), 32'd0);
        chk("clr_udf", 32'(a_udf), 32'd0);
        chk("clr_valid", 32'(a_rd_valid), 32'd0);
        chk("clr_hold", 32'(a_rd_data), 32'h11);

        // Write+read at empty: write accepted, read rejected
        a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 8'h77;
        tick();
        a_wr_en = 1'b0;
        chk("emptyboth_level", 32'(a_level), 32'd1);
        chk("emptyboth_udf", 32'(a_udf), 32'd1);
        chk("emptyboth_valid", 32'(a_rd_valid), 32'd0);
        tick();
        a_rd_en = 1'b0;
        chk("emptyboth_data", 32'(a_rd_data), 32'h77);
        chk("emptyboth_valid2", 32'(a_rd_valid), 32'd1);
        a_clr = 1'b1; tick(); a_clr = 1'b0;

        // Random stream of 3000 words against a queue model
        wcnt = 0; cyc = 0;
        while ((wcnt < 3000 || q.size() != 0) && cyc < 20000) begin
            w = (wcnt < 3000) && ($urandom_range(0, 99) < 55);
            r = (wcnt >= 3000) || ($urandom_range(0, 99) < 50);
            wacc = w && (q.size() < 1024);
            racc = r && (q.size() != 0);
            a_wr_en = w; a_rd_en = r; a_wr_data = 8'($urandom);
            tick();
            if (racc) begin
                exp_d = q.pop_front();
                chk("stream_data", 32'(a_rd_data), 32'(exp_d));
            end
            chk("stream_valid", 32'(a_rd_valid), 32'(racc));
            if (wacc) begin
                q.push_back(a_wr_data);
                wcnt++;
            end
            chk("stream_level", 32'(a_level), 32'(q.size()));
            cyc++;
        end
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        chk("stream_written", 32'(wcnt), 32'd3000);
        chk("stream_drained", 32'(q.size()), 32'd0);

        // FWFT instance
        chk("b_idle_valid", 32'(b_rd_valid), 32'd0);
        b_wr_en = 1'b1; b_wr_data = 16'hBEEF;
        tick();
        b_wr_en = 1'b0;
        chk("b_beef_valid", 32'(b_rd_valid), 32'd1);
        chk("b_beef_data", 32'(b_rd_data), 32'hBEEF);
        chk("b_beef_level", 32'(b_level), 32'd1);
        b_rd_en = 1'b1; tick(); b_rd_en = 1'b0;
        chk("b_pop_valid", 32'(b_rd_valid), 32'd0);
        chk("b_pop_empty", 32'(b_empty), 32'd1);
        b_wr_en = 1'b1;
        b_wr_data = 16'h1111; tick();
        b_wr_data = 16'h2222; tick();
        b_wr_data = 16'h3333; tick();
        b_wr_en = 1'b0;
        chk("b_head", 32'(b_rd_data), 32'h1111);
        chk("b_level3", 32'(b_level), 32'd3);
        b_rd_en = 1'b1; tick(); b_rd_en = 1'b0;
        chk("b_head2", 32'(b_rd_data), 32'h2222);
        b_wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b_wr_data = 16'(16'h4000 + i);
            tick();
        end
        chk("b_full", 32'(b_full), 32'd1);
        chk("b_af", 32'(b_af), 32'd1);
        chk("b_level8", 32'(b_level), 32'd8);
        tick();
        b_wr_en = 1'b0;
        chk("b_ovf", 32'(b_ovf), 32'd1);
        chk("b_head3", 32'(b_rd_data), 32'h2222);

        // Asynchronous reset mid-stream, checked before the next clock edge
        a_wr_en = 1'b1; a_wr_data = 8'h9C; tick();
        a_rd_en = 1'b1; tick();
        rst_n = 1'b0;
        #1;
        chk("arst_a_level", 32'(a_level), 32'd0);
        chk("arst_a_empty", 32'(a_empty), 32'd1);
        chk("arst_a_valid", 32'(a_rd_valid), 32'd0);
        chk("arst_a_data", 32'(a_rd_data), 32'd0);
        chk("arst_b_level", 32'(b_level), 32'd0);
        chk("arst_b_valid", 32'(b_rd_valid), 32'd0);
        chk("arst_b_full", 32'(b_full), 32'd0);
        chk("arst_b_ovf", 32'(b_ovf), 32'd0);
        chk("arst_b_ae", 32'(b_ae), 32'd1);
        chk("arst_b_af", 32'(b_af), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
